// File: rtl/rr_arbiter_4.sv
// ---------------------------------------------------------------------------
// rr_arbiter_4
//   Round-robin arbiter sharing one resource among four requesters.
//   One owner at a time. The grant is presented both as a registered 2-bit
//   owner index and as a registered one-hot vector. The one-hot vector always
//   equals the decode of the index, gated by gnt_valid.
//   Every release is followed by exactly one IDLE cycle. During that cycle
//   the next winner is chosen, searching upward from the rotating priority
//   pointer.
//
// Optional build macro:
//   ARB_TIMEOUT_EN - adds an 8-bit hold counter (parameter MAX_HOLD, range
//                    2..255). The owner is force-released after MAX_HOLD
//                    grant cycles whenever another requester is waiting.
//
// Ports:
//   clk        in   1  rising-edge clock
//   rst_n      in   1  asynchronous active-low reset
//   en         in   1  enable; 0 blocks new grants, never revokes a held one
//   req        in   4  level-sensitive request vector, bit i = requester i
//   gnt        out  4  registered one-hot grant, zero when no owner
//   gnt_id     out  2  registered owner index, meaningful while gnt_valid=1
//   gnt_valid  out  1  registered, high while a grant is held
// ---------------------------------------------------------------------------
module rr_arbiter_4
`ifdef ARB_TIMEOUT_EN
#(
    parameter int MAX_HOLD = 8
)
`endif
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_valid
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state_r;
    state_t     state_s;
    logic [1:0] ptr_r;
    logic [1:0] ptr_s;
    logic [1:0] id_r;
    logic [1:0] id_s;
    logic       valid_r;
    logic       valid_s;
    logic [3:0] gnt_r;
    logic [1:0] winner_s;
    logic       release_s;

    // First set request bit found by searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
    // The loop runs from the farthest offset down so the nearest one wins.
    function automatic logic [1:0] pick_winner(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] w;
        logic [1:0] idx;
        w = p;
        for (int i = 3; i >= 0; i--) begin
            idx = p + i[1:0];
            if (r[idx]) begin
                w = idx;
            end else begin
                w = w;
            end
        end
        return w;
    endfunction

    // Index-to-one-hot decode, gated by the valid flag.
    function automatic logic [3:0] decode_grant(input logic [1:0] id, input logic v);
        logic [3:0] oh;
        oh = 4'b0000;
        if (v) begin
            oh[id] = 1'b1;
        end else begin
            oh = 4'b0000;
        end
        return oh;
    endfunction

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] cnt_r;
    logic [7:0] cnt_s;
    logic       others_s;
    logic       timeout_s;

    // Owner release: owner dropped its request, or it used up its hold budget
    // while another requester is waiting.
    always_comb begin
        others_s  = |(req & ~decode_grant(id_r, 1'b1));
        timeout_s = (cnt_r == HOLD_LAST) && others_s;
        release_s = !req[id_r] || timeout_s;
    end

    // Hold counter: cleared on each new grant, counts up every held cycle,
    // and saturates at HOLD_LAST.
    always_comb begin
        cnt_s = cnt_r;
        if ((state_r == IDLE) && en && (req != 4'b0000)) begin
            cnt_s = 8'd0;
        end else if ((state_r == GRANT) && (cnt_r != HOLD_LAST)) begin
            cnt_s = cnt_r + 8'd1;
        end else begin
            cnt_s = cnt_r;
        end
    end

    // Hold counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 8'd0;
        end else begin
            cnt_r <= cnt_s;
        end
    end
`else
    // Owner release: only when the owner drops its request.
    always_comb begin
        release_s = !req[id_r];
    end
`endif

    // Winner among the current requests, searched from the priority pointer.
    always_comb begin
        winner_s = pick_winner(req, ptr_r);
    end

    // Next-state and next-output logic for the IDLE/GRANT controller.
    always_comb begin
        state_s = state_r;
        ptr_s   = ptr_r;
        id_s    = id_r;
        valid_s = valid_r;
        case (state_r)
            IDLE: begin
                if (en && (req != 4'b0000)) begin
                    id_s    = winner_s;
                    valid_s = 1'b1;
                    state_s = GRANT;
                end else begin
                    valid_s = 1'b0;
                    state_s = IDLE;
                end
            end
            GRANT: begin
                // en is deliberately ignored here; a held grant is never revoked by it
                if (release_s) begin
                    valid_s = 1'b0;
                    ptr_s   = id_r + 2'd1;
                    state_s = IDLE;
                end else begin
                    valid_s = 1'b1;
                    state_s = GRANT;
                end
            end
            default: begin
                valid_s = 1'b0;
                state_s = IDLE;
            end
        endcase
    end

    // Controller state and registered grant outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            ptr_r   <= 2'b00;
            id_r    <= 2'b00;
            valid_r <= 1'b0;
            gnt_r   <= 4'b0000;
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
            id_r    <= id_s;
            valid_r <= valid_s;
            gnt_r   <= decode_grant(id_s, valid_s);
        end
    end

    assign gnt       = gnt_r;
    assign gnt_id    = id_r;
    assign gnt_valid = valid_r;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// ---------------------------------------------------------------------------
// tb_rr_arbiter_4
//   Directed bench for rr_arbiter_4. Each step drives en/req and pushes the
//   expected post-edge grant onto a scoreboard queue. The entry is popped and
//   compared 1 ns after the rising edge. The timeout scenarios are compiled
//   in only when ARB_TIMEOUT_EN is defined; that build uses MAX_HOLD=4.
// ---------------------------------------------------------------------------
module tb_rr_arbiter_4;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;

    typedef struct {
        logic       valid;
        logic [1:0] id;
    } exp_t;

    exp_t sb[$];
    int   checks;
    int   errors;

`ifdef ARB_TIMEOUT_EN
    rr_arbiter_4 #(.MAX_HOLD(4)) dut (
`else
    rr_arbiter_4 dut (
`endif
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of stimulus, then compare the outputs after the edge
    // against the scoreboard entry.
    task automatic step(input string tag, input logic e, input logic [3:0] r,
                        input logic v, input logic [1:0] id);
        exp_t       x;
        logic [3:0] oh;
        en  = e;
        req = r;
        sb.push_back('{valid: v, id: id});
        @(posedge clk);
        #1;
        x  = sb.pop_front();
        oh = 4'b0000;
        if (x.valid) oh[x.id] = 1'b1;
        check({tag, ".valid"}, {3'b000, gnt_valid}, {3'b000, x.valid});
        check({tag, ".gnt"}, gnt, oh);
        if (x.valid) check({tag, ".id"}, {2'b00, gnt_id}, {2'b00, x.id});
    endtask

    task automatic do_reset(input string tag);
        en    = 1'b0;
        req   = 4'b0000;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check({tag, ".gnt"}, gnt, 4'b0000);
        check({tag, ".id"}, {2'b00, gnt_id}, 4'b0000);
        check({tag, ".valid"}, {3'b000, gnt_valid}, 4'b0000);
        #3;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] r;
        checks = 0;
        errors = 0;
        do_reset("rst0");

        // Single request, then release; the next search starts at 3.
        step("t1_grant", 1'b1, 4'b0100, 1'b1, 2'd2);
        step("t1_hold",  1'b1, 4'b0100, 1'b1, 2'd2);
        step("t1_drop",  1'b1, 4'b0000, 1'b0, 2'd0);
        step("t1_ptr3",  1'b1, 4'b1111, 1'b1, 2'd3);
        step("t1_hold3", 1'b1, 4'b1111, 1'b1, 2'd3);
        step("t1_rel3",  1'b1, 4'b0111, 1'b0, 2'd0);

        // All requesting: rotation 0,1,2,3,0 with one idle cycle between grants.
        for (int k = 0; k < 5; k++) begin
            r = 4'b1111;
            r[k % 4] = 1'b0;
            step("t2_grant", 1'b1, 4'b1111, 1'b1, 2'(k % 4));
            step("t2_hold",  1'b1, 4'b1111, 1'b1, 2'(k % 4));
            step("t2_idle",  1'b1, r,       1'b0, 2'd0);
        end

        // en=0 blocks new grants, but does not revoke a held one.
        do_reset("rst1");
        for (int k = 0; k < 5; k++) step("t3_blocked", 1'b0, 4'b0011, 1'b0, 2'd0);
        step("t3_enable", 1'b1, 4'b0011, 1'b1, 2'd0);
        step("t3_keep_a", 1'b0, 4'b0011, 1'b1, 2'd0);
        step("t3_keep_b", 1'b0, 4'b0011, 1'b1, 2'd0);
        step("t3_rel",    1'b1, 4'b0010, 1'b0, 2'd0);
        step("t3_next1",  1'b1, 4'b0010, 1'b1, 2'd1);

        // Asynchronous reset mid-grant clears outputs at once and resets ptr to 0.
        #2;
        rst_n = 1'b0;
        #1;
        check("t4_async_gnt", gnt, 4'b0000);
        check("t4_async_valid", {3'b000, gnt_valid}, 4'b0000);
        #2;
        rst_n = 1'b1;
        step("t4_ptr0",  1'b1, 4'b0011, 1'b1, 2'd0);
        step("t4_rel",   1'b1, 4'b0010, 1'b0, 2'd0);
        step("t4_next1", 1'b1, 4'b0010, 1'b1, 2'd1);
        step("t4_end",   1'b1, 4'b0000, 1'b0, 2'd0);

`ifdef ARB_TIMEOUT_EN
        // Forced release after 4 held cycles while the other requester waits.
        do_reset("rst2");
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 4; c++) step("t5_hold", 1'b1, 4'b0011, 1'b1, 2'(k % 2));
            step("t5_idle", 1'b1, 4'b0011, 1'b0, 2'd0);
        end

        // A lone requester keeps the grant indefinitely.
        do_reset("rst3");
        for (int k = 0; k < 25; k++) step("t6_lone", 1'b1, 4'b0001, 1'b1, 2'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
